// File: rtl/program_loader.sv
// Byte-stream program loader: reads a 16-bit little-endian word count,
// then packs the following bytes little-endian into 32-bit words and writes
// them into instruction memory. The core is held in reset until a load
// completes.
//
//   state | meaning
//   IDLE  | waiting for the first LDstart after reset
//   HDR0  | receiving word-count low byte
//   HDR1  | receiving word-count high byte, range check
//   DATA  | assembling an instruction word, one byte lane per byte
//   WRITE | one-cycle memory write strobe for the assembled word
//   DONE  | image loaded, core released from reset
//   ERROR | word count exceeded DEPTH, core stays in reset
module program_loader #(
    parameter int          DEPTH = 256,
    parameter logic [31:0] BASE  = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        LDstart,
    input  logic [7:0]  LDbyte,
    input  logic        LDvalid,
    output logic        LDready,
    output logic [31:0] LDwaddr,
    output logic [31:0] LDwdata,
    output logic        LDwenable,
    output logic        LDcpu_reset,
    output logic        LDdone,
    output logic        LDerror,
    output logic [15:0] LDcount
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR0  = 3'd1,
        HDR1  = 3'd2,
        DATA  = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5,
        ERROR = 3'd6
    } state_t;

    // One bit wider than the header so a DEPTH of 65536 still compares correctly.
    localparam logic [16:0] DEPTH_L = 17'(DEPTH);

    state_t      state, state_nxt;
    logic [15:0] n_q;
    logic [1:0]  idx_q;
    logic [31:0] wdata_q;
    logic [15:0] count_q;

    logic        take;
    logic [15:0] n_hdr;
    logic [15:0] count_inc;

    assign take      = LDvalid & LDready;
    assign n_hdr     = {LDbyte, n_q[7:0]};
    assign count_inc = count_q + 16'd1;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and state-derived outputs.
    always_comb begin
        state_nxt   = state;
        LDready     = 1'b0;
        LDwenable   = 1'b0;
        LDdone      = 1'b0;
        LDerror     = 1'b0;
        LDcpu_reset = 1'b1;
        LDwaddr     = 32'h0;
        unique case (state)
            IDLE: begin
                if (LDstart) state_nxt = HDR0;
            end
            HDR0: begin
                LDready = 1'b1;
                if (take) state_nxt = HDR1;
            end
            HDR1: begin
                LDready = 1'b1;
                if (take) begin
                    if (n_hdr == 16'd0)                 state_nxt = DONE;
                    else if ({1'b0, n_hdr} > DEPTH_L)   state_nxt = ERROR;
                    else                                state_nxt = DATA;
                end
            end
            DATA: begin
                LDready = 1'b1;
                if (take && idx_q == 2'd3) state_nxt = WRITE;
            end
            WRITE: begin
                LDwenable = 1'b1;
                LDwaddr   = BASE + {14'd0, count_q, 2'b00};
                state_nxt = (count_inc == n_q) ? DONE : DATA;
            end
            DONE: begin
                LDdone      = 1'b1;
                LDcpu_reset = 1'b0;
                if (LDstart) state_nxt = HDR0;
            end
            ERROR: begin
                LDerror = 1'b1;
                if (LDstart) state_nxt = HDR0;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Header capture, word assembly and write counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            n_q     <= 16'd0;
            idx_q   <= 2'd0;
            wdata_q <= 32'h0;
            count_q <= 16'd0;
        end else begin
            unique case (state)
                IDLE, DONE, ERROR: begin
                    if (LDstart) begin
                        count_q <= 16'd0;
                        idx_q   <= 2'd0;
                    end
                end
                HDR0: begin
                    if (take) n_q[7:0] <= LDbyte;
                end
                HDR1: begin
                    if (take) n_q[15:8] <= LDbyte;
                end
                DATA: begin
                    // idx_q wraps 3->0 naturally, ready for the next word.
                    if (take) begin
                        wdata_q[{idx_q, 3'b000} +: 8] <= LDbyte;
                        idx_q                         <= idx_q + 2'd1;
                    end
                end
                WRITE: begin
                    count_q <= count_inc;
                end
                default: ;
            endcase
        end
    end

    assign LDwdata = wdata_q;
    assign LDcount = count_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: basic, empty, oversize, reset mid-word,
// gapped stream and restart loads.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        ld_start;
    logic [7:0]  ld_byte;
    logic        ld_valid;
    logic        ld_ready;
    logic [31:0] ld_waddr;
    logic [31:0] ld_wdata;
    logic        ld_wenable;
    logic        ld_cpu_reset;
    logic        ld_done;
    logic        ld_error;
    logic [15:0] ld_count;

    program_loader #(.DEPTH(256), .BASE(32'h0)) dut (
        .clk         (clk),
        .reset       (reset),
        .LDstart     (ld_start),
        .LDbyte      (ld_byte),
        .LDvalid     (ld_valid),
        .LDready     (ld_ready),
        .LDwaddr     (ld_waddr),
        .LDwdata     (ld_wdata),
        .LDwenable   (ld_wenable),
        .LDcpu_reset (ld_cpu_reset),
        .LDdone      (ld_done),
        .LDerror     (ld_error),
        .LDcount     (ld_count)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [7:0] basic_img [0:9] = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10,
                                    8'h00, 8'h93, 8'h05, 8'h20, 8'h00};

    logic [31:0] wr_addr [0:63];
    logic [31:0] wr_data [0:63];
    int          wr_total  = 0;
    int          we_double = 0;
    logic        we_prev   = 1'b0;

    // Write log and back-to-back strobe detector, sampled on the falling edge.
    always @(negedge clk) begin
        if (ld_wenable) begin
            if (wr_total < 64) begin
                wr_addr[wr_total] = ld_waddr;
                wr_data[wr_total] = ld_wdata;
            end
            wr_total++;
        end
        if (ld_wenable && we_prev) we_double++;
        we_prev = ld_wenable;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic pulse_start();
        ld_start = 1'b1;
        cyc();
        ld_start = 1'b0;
    endtask

    // Present one byte after 'gap' idle cycles and hold it until consumed.
    task automatic send(input logic [7:0] b, input int gap);
        ld_valid = 1'b0;
        repeat (gap) cyc();
        ld_valid = 1'b1;
        ld_byte  = b;
        for (int t = 0; t < 50; t++) begin
            if (ld_ready) begin
                cyc();
                ld_valid = 1'b0;
                return;
            end
            cyc();
        end
        check("send_timeout", {31'd0, ld_ready}, 32'd1);
        ld_valid = 1'b0;
    endtask

    task automatic wait_end();
        for (int t = 0; t < 50; t++) begin
            if (ld_done || ld_error) return;
            cyc();
        end
        check("end_timeout", {31'd0, ld_done | ld_error}, 32'd1);
    endtask

    // gapped=1: one idle cycle before each byte, except the first byte of
    // word 2, which is presented during WRITE and must be held.
    task automatic load_basic(input int gapped);
        for (int i = 0; i < 10; i++) begin
            send(basic_img[i], (gapped != 0 && i != 6) ? 1 : 0);
        end
    endtask

    task automatic check_basic(input string tag, input int w0);
        wait_end();
        cyc();
        check({tag, "_done"},   {31'd0, ld_done}, 32'd1);
        check({tag, "_cpurst"}, {31'd0, ld_cpu_reset}, 32'd0);
        check({tag, "_count"},  {16'd0, ld_count}, 32'd2);
        check({tag, "_nwr"},    wr_total - w0, 32'd2);
        check({tag, "_a0"},     wr_addr[w0], 32'h0);
        check({tag, "_d0"},     wr_data[w0], 32'h00100513);
        check({tag, "_a1"},     wr_addr[w0 + 1], 32'h4);
        check({tag, "_d1"},     wr_data[w0 + 1], 32'h00200593);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        reset    = 1'b1;
        ld_start = 1'b0;
        ld_valid = 1'b0;
        ld_byte  = 8'h00;
        repeat (2) cyc();
        check("rst_cpurst", {31'd0, ld_cpu_reset}, 32'd1);
        check("rst_ready",  {31'd0, ld_ready}, 32'd0);
        check("rst_wen",    {31'd0, ld_wenable}, 32'd0);
        check("rst_done",   {31'd0, ld_done}, 32'd0);
        check("rst_err",    {31'd0, ld_error}, 32'd0);
        check("rst_count",  {16'd0, ld_count}, 32'd0);
        check("rst_waddr",  ld_waddr, 32'h0);
        check("rst_wdata",  ld_wdata, 32'h0);
        reset = 1'b0;
        cyc();
        check("idle_ready", {31'd0, ld_ready}, 32'd0);

        // Basic load with write latency check on the first word.
        w0 = wr_total;
        pulse_start();
        check("hdr0_ready",  {31'd0, ld_ready}, 32'd1);
        check("hdr0_cpurst", {31'd0, ld_cpu_reset}, 32'd1);
        for (int i = 0; i < 6; i++) send(basic_img[i], 0);
        check("lat_wen",   {31'd0, ld_wenable}, 32'd1);
        check("lat_waddr", ld_waddr, 32'h0);
        check("lat_wdata", ld_wdata, 32'h00100513);
        check("lat_ready", {31'd0, ld_ready}, 32'd0);
        for (int i = 6; i < 10; i++) send(basic_img[i], 0);
        check_basic("basic", w0);

        // Restart into an empty image.
        w0 = wr_total;
        pulse_start();
        check("rs_cpurst", {31'd0, ld_cpu_reset}, 32'd1);
        check("rs_count",  {16'd0, ld_count}, 32'd0);
        check("rs_done",   {31'd0, ld_done}, 32'd0);
        send(8'h00, 0);
        send(8'h00, 0);
        check("empty_done",   {31'd0, ld_done}, 32'd1);
        check("empty_cpurst", {31'd0, ld_cpu_reset}, 32'd0);
        check("empty_count",  {16'd0, ld_count}, 32'd0);
        cyc();
        check("empty_nwr", wr_total - w0, 32'd0);

        // Oversize image, N = 257.
        w0 = wr_total;
        pulse_start();
        send(8'h01, 0);
        send(8'h01, 0);
        check("over_err",    {31'd0, ld_error}, 32'd1);
        check("over_ready",  {31'd0, ld_ready}, 32'd0);
        check("over_cpurst", {31'd0, ld_cpu_reset}, 32'd1);
        check("over_done",   {31'd0, ld_done}, 32'd0);
        repeat (3) cyc();
        check("over_nwr", wr_total - w0, 32'd0);

        // N = DEPTH is accepted; then reset after two data bytes.
        w0 = wr_total;
        pulse_start();
        send(8'h00, 0);
        send(8'h01, 0);
        check("depth_err",   {31'd0, ld_error}, 32'd0);
        check("depth_ready", {31'd0, ld_ready}, 32'd1);
        send(8'h13, 0);
        send(8'h05, 0);
        reset    = 1'b1;
        ld_start = 1'b1;
        ld_valid = 1'b1;
        ld_byte  = 8'h10;
        cyc();
        check("mid_ready",  {31'd0, ld_ready}, 32'd0);
        check("mid_count",  {16'd0, ld_count}, 32'd0);
        check("mid_wdata",  ld_wdata, 32'h0);
        check("mid_cpurst", {31'd0, ld_cpu_reset}, 32'd1);
        check("mid_wen",    {31'd0, ld_wenable}, 32'd0);
        reset    = 1'b0;
        ld_start = 1'b0;
        ld_valid = 1'b0;
        cyc();
        check("mid_idle", {31'd0, ld_ready}, 32'd0);
        check("mid_nwr",  wr_total - w0, 32'd0);

        w0 = wr_total;
        pulse_start();
        load_basic(0);
        check_basic("reload", w0);

        // Gapped stream with a byte held through WRITE.
        w0 = wr_total;
        pulse_start();
        load_basic(1);
        check_basic("gap", w0);

        // Restart from DONE with a one-word image.
        w0 = wr_total;
        pulse_start();
        check("rs2_cpurst", {31'd0, ld_cpu_reset}, 32'd1);
        check("rs2_count",  {16'd0, ld_count}, 32'd0);
        send(8'h01, 0);
        send(8'h00, 0);
        send(8'hef, 0);
        send(8'hbe, 0);
        send(8'had, 0);
        send(8'hde, 0);
        wait_end();
        cyc();
        check("one_nwr",   wr_total - w0, 32'd1);
        check("one_addr",  wr_addr[w0], 32'h0);
        check("one_data",  wr_data[w0], 32'hdeadbeef);
        check("one_count", {16'd0, ld_count}, 32'd1);
        check("one_done",  {31'd0, ld_done}, 32'd1);

        check("we_single", we_double, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
